alu_operand_sequencer: RTL and testbench

- Upstream feeder for the two-multiply/two-add fixed-point ALU: `a*b + c*d + e`, or add mode with `f_add`.
- Accepts a job command and a stream of operand words over valid/ready.
- Drives the ALU operand bus, `reg_en` and `f_add`, then captures the ALU result after a fixed latency.
- Presents the captured result on a valid/ready output; one job in flight.

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_operand_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_operand_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU operand sequencer: FSM states,
// operand slot indices and the per-mode slot walk.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } seq_state_e;

    localparam int NUM_OPS = 5;

    // Operand slots, in the order the ALU registers are laid out on reg_en.
    localparam logic [2:0] SLOT_A = 3'd0;
    localparam logic [2:0] SLOT_B = 3'd1;
    localparam logic [2:0] SLOT_C = 3'd2;
    localparam logic [2:0] SLOT_D = 3'd3;
    localparam logic [2:0] SLOT_E = 3'd4;

    // In add mode the A word also strobes B and D; the ALU clears those
    // registers when f_add is set, so both products collapse to zero.
    localparam logic [NUM_OPS-1:0] ADD_A_MASK = 5'b01011;

    // Both modes end on E; add mode skips B and D by stepping two slots.
    localparam logic [2:0] LAST_SLOT_MUL = SLOT_E;
    localparam logic [2:0] LAST_SLOT_ADD = SLOT_E;
    localparam logic [2:0] SLOT_STEP_MUL = 3'd1;
    localparam logic [2:0] SLOT_STEP_ADD = 3'd2;

    // Register-enable pattern for the word being loaded into a given slot.
    function automatic logic [NUM_OPS-1:0] slot_enable(input logic [2:0] slot,
                                                       input logic       add_mode);
        if (add_mode && (slot == SLOT_A)) begin
            return ADD_A_MASK;
        end
        return NUM_OPS'(1) << slot;
    endfunction

endpackage

// File: rtl/alu_operand_sequencer.sv
// Feeds a job's operand words into the fixed-point ALU's five operand
// registers, waits the ALU's result latency, then offers the captured
// result downstream. One job in flight at a time.
//
// Handshakes: every channel is valid/ready. A transfer happens on a rising
// edge where valid and ready are both high. Ready never depends on the same
// channel's valid; cmd_ready depends on res_ready only in OUT, so a new job
// can start in the same cycle the previous result is consumed.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int RES_LAT   = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cmd_valid,
    input  logic                                 cmd_add,
    output logic                                 cmd_ready,
    input  logic                                 in_valid,
    input  logic [BUS_WIDTH-1:0]                 in_data,
    output logic                                 in_ready,
    output logic [NUM_OPS-1:0][BUS_WIDTH-1:0]    ops,
    output logic [NUM_OPS-1:0]                   reg_en,
    output logic                                 f_add,
    input  logic [BUS_WIDTH-1:0]                 alu_result,
    output logic                                 res_valid,
    output logic [BUS_WIDTH-1:0]                 res_data,
    input  logic                                 res_ready
);

    localparam int CW = (RES_LAT < 2) ? 1 : $clog2(RES_LAT + 1);

    seq_state_e                              state_q, state_d;
    logic [2:0]                              slot_q, slot_d;
    logic [CW-1:0]                           cnt_q, cnt_d;
    logic                                    f_add_q, f_add_d;
    logic [NUM_OPS-1:0][BUS_WIDTH-1:0]       ops_q, ops_d;
    logic [NUM_OPS-1:0]                      reg_en_q, reg_en_d;
    logic                                    res_valid_q, res_valid_d;
    logic [BUS_WIDTH-1:0]                    res_data_q, res_data_d;

    logic       cmd_fire;
    logic [2:0] last_slot;
    logic [2:0] slot_step;

    assign cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_OUT) && res_ready);
    assign in_ready  = (state_q == ST_LOAD);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign last_slot = f_add_q ? LAST_SLOT_ADD : LAST_SLOT_MUL;
    assign slot_step = f_add_q ? SLOT_STEP_ADD : SLOT_STEP_MUL;

    assign ops       = ops_q;
    assign reg_en    = reg_en_q;
    assign f_add     = f_add_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    // Next-state: job acceptance, operand slot walk, latency count, result hold.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        cnt_d       = cnt_q;
        f_add_d     = f_add_q;
        ops_d       = ops_q;
        reg_en_d    = '0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    f_add_d = cmd_add;
                    slot_d  = SLOT_A;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    ops_d    = {NUM_OPS{in_data}};
                    reg_en_d = slot_enable(slot_q, f_add_q);
                    if (slot_q == last_slot) begin
                        cnt_d   = CW'(RES_LAT);
                        state_d = ST_WAIT;
                    end else begin
                        slot_d = slot_q + slot_step;
                    end
                end
            end
            ST_WAIT: begin
                // Count reaches zero in the cycle the ALU output is settled.
                if (cnt_q == '0) begin
                    res_data_d  = alu_result;
                    res_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (cmd_fire) begin
                        f_add_d = cmd_add;
                        slot_d  = SLOT_A;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any job in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            slot_q      <= SLOT_A;
            cnt_q       <= '0;
            f_add_q     <= 1'b0;
            ops_q       <= '0;
            reg_en_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            f_add_q     <= f_add_d;
            ops_q       <= ops_d;
            reg_en_q    <= reg_en_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer. Two instances share the operand
// stream: u1 with RES_LAT=1 and u3 with RES_LAT=3 (only given a command in the
// first job). Each drives a small ALU model: five unreset operand registers,
// B/D cleared when f_add, result = (A*B>>7) + (C*D>>7) + E (Q1.7 products).
module tb_alu_operand_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic cmd_valid, cmd_valid3, cmd_add;
    logic in_valid;
    logic [7:0] in_data;
    logic res_ready, res_ready3;

    logic            cmd_ready1, in_ready1, f_add1, res_valid1;
    logic [4:0][7:0] ops1;
    logic [4:0]      reg_en1;
    logic [7:0]      res_data1, alu_result1;

    logic            cmd_ready3, in_ready3, f_add3, res_valid3;
    logic [4:0][7:0] ops3;
    logic [4:0]      reg_en3;
    logic [7:0]      res_data3, alu_result3;

    logic [7:0] alu1_q [5];
    logic [7:0] alu3_q [5];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.BUS_WIDTH(8), .RES_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_add(cmd_add), .cmd_ready(cmd_ready1),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .ops(ops1), .reg_en(reg_en1), .f_add(f_add1),
        .alu_result(alu_result1),
        .res_valid(res_valid1), .res_data(res_data1), .res_ready(res_ready)
    );

    alu_operand_sequencer #(.BUS_WIDTH(8), .RES_LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid3), .cmd_add(cmd_add), .cmd_ready(cmd_ready3),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready3),
        .ops(ops3), .reg_en(reg_en3), .f_add(f_add3),
        .alu_result(alu_result3),
        .res_valid(res_valid3), .res_data(res_data3), .res_ready(res_ready3)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d,
                                         input logic [7:0] e);
        logic [15:0] p;
        logic [15:0] q;
        p = a * b;
        q = c * d;
        return 8'(p >> 7) + 8'(q >> 7) + e;
    endfunction

    // ALU operand registers for each instance (no reset, like the real ALU).
    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (reg_en1[i]) alu1_q[i] <= (f_add1 && (i == 1 || i == 3)) ? 8'd0 : ops1[i];
            if (reg_en3[i]) alu3_q[i] <= (f_add3 && (i == 1 || i == 3)) ? 8'd0 : ops3[i];
        end
    end

    assign alu_result1 = alu_f(alu1_q[0], alu1_q[1], alu1_q[2], alu1_q[3], alu1_q[4]);
    assign alu_result3 = alu_f(alu3_q[0], alu3_q[1], alu3_q[2], alu3_q[3], alu3_q[4]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one word to u1 for one edge, then check the resulting pulse.
    task automatic put_word(input logic [7:0] w, input logic [4:0] en, input string tag);
        logic [39:0] bc;
        in_valid = 1'b1;
        in_data  = w;
        tick();
        bc = {5{w}};
        chk({tag, " reg_en"}, 64'(reg_en1), 64'(en));
        chk({tag, " ops"}, 64'(ops1), 64'(bc));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " res_valid"}, 64'(res_valid1), 64'd0);
        chk({tag, " reg_en"},    64'(reg_en1),    64'd0);
        chk({tag, " f_add"},     64'(f_add1),     64'd0);
        chk({tag, " cmd_ready"}, 64'(cmd_ready1), 64'd1);
        chk({tag, " in_ready"},  64'(in_ready1),  64'd0);
        chk({tag, " ops"},       64'(ops1),       64'd0);
        chk({tag, " res_data"},  64'(res_data1),  64'd0);
    endtask

    initial begin
        logic [7:0] wb [5];
        logic [4:0] en;

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_valid3 = 1'b0; cmd_add = 1'b0;
        in_valid = 1'b0; in_data = 8'd0;
        res_ready = 1'b0; res_ready3 = 1'b0;

        // Reset
        repeat (3) tick();
        chk_reset_vals("reset");
        chk("reset u3 res_valid", 64'(res_valid3), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle cmd_ready", 64'(cmd_ready1), 64'd1);
        chk("idle in_ready", 64'(in_ready1), 64'd0);

        // Mult job, back-to-back words; both instances take it
        cmd_valid = 1'b1; cmd_valid3 = 1'b1; cmd_add = 1'b0;
        tick();
        cmd_valid = 1'b0; cmd_valid3 = 1'b0;
        chk("m1 in_ready", 64'(in_ready1), 64'd1);
        chk("m1 cmd_ready", 64'(cmd_ready1), 64'd0);
        chk("m1 u3 in_ready", 64'(in_ready3), 64'd1);
        put_word(8'd8,  5'b00001, "m1 A");
        put_word(8'h40, 5'b00010, "m1 B");
        put_word(8'd6,  5'b00100, "m1 C");
        put_word(8'h40, 5'b01000, "m1 D");
        put_word(8'd10, 5'b10000, "m1 E");
        in_valid = 1'b0;
        chk("m1 wait in_ready", 64'(in_ready1), 64'd0);
        tick();
        chk("m1 pulse end", 64'(reg_en1), 64'd0);
        chk("m1 early res_valid", 64'(res_valid1), 64'd0);
        tick();
        chk("m1 res_valid", 64'(res_valid1), 64'd1);
        chk("m1 res_data", 64'(res_data1), 64'd17);
        chk("m1 u3 res_valid +0", 64'(res_valid3), 64'd0);
        tick();
        chk("m1 hold res_valid", 64'(res_valid1), 64'd1);
        chk("m1 u3 res_valid +1", 64'(res_valid3), 64'd0);
        tick();
        chk("m1 u3 res_valid +2", 64'(res_valid3), 64'd1);
        chk("m1 u3 res_data", 64'(res_data3), 64'd17);
        res_ready = 1'b1; res_ready3 = 1'b1;
        #1;
        chk("m1 out cmd_ready", 64'(cmd_ready1), 64'd1);
        tick();
        res_ready = 1'b0; res_ready3 = 1'b0;
        chk("m1 consumed", 64'(res_valid1), 64'd0);
        chk("m1 u3 consumed", 64'(res_valid3), 64'd0);
        chk("m1 f_add", 64'(f_add1), 64'd0);

        // Add job
        cmd_valid = 1'b1; cmd_add = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("add f_add start", 64'(f_add1), 64'd1);
        put_word(8'd5, 5'b01011, "add A");
        chk("add f_add A", 64'(f_add1), 64'd1);
        put_word(8'd7, 5'b00100, "add C");
        put_word(8'd9, 5'b10000, "add E");
        in_valid = 1'b0;
        tick();
        tick();
        chk("add res_valid", 64'(res_valid1), 64'd1);
        chk("add res_data", 64'(res_data1), 64'd9);
        chk("add f_add end", 64'(f_add1), 64'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Bubbles between words, then result backpressure
        cmd_valid = 1'b1; cmd_add = 1'b0;
        tick();
        cmd_valid = 1'b0;
        wb = '{8'h80, 8'd20, 8'h40, 8'd30, 8'd3};
        for (int k = 0; k < 5; k++) begin
            en = 5'b00001 << k;
            put_word(wb[k], en, "bub word");
            in_valid = 1'b0;
            if (k < 4) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    chk("bub gap reg_en", 64'(reg_en1), 64'd0);
                    chk("bub gap ops", 64'(ops1[0]), 64'(wb[k]));
                end
            end
        end
        tick();
        tick();
        chk("bub res_valid", 64'(res_valid1), 64'd1);
        chk("bub res_data", 64'(res_data1), 64'd38);
        cmd_valid = 1'b1; cmd_add = 1'b0;
        in_valid = 1'b1; in_data = 8'hEE;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("bp res_valid", 64'(res_valid1), 64'd1);
            chk("bp res_data", 64'(res_data1), 64'd38);
            chk("bp cmd_ready", 64'(cmd_ready1), 64'd0);
            chk("bp in_ready", 64'(in_ready1), 64'd0);
            chk("bp reg_en", 64'(reg_en1), 64'd0);
        end

        // Overlap: consume result and accept next job in the same cycle
        res_ready = 1'b1;
        #1;
        chk("ov cmd_ready", 64'(cmd_ready1), 64'd1);
        tick();
        res_ready = 1'b0; cmd_valid = 1'b0;
        chk("ov res_valid", 64'(res_valid1), 64'd0);
        chk("ov in_ready", 64'(in_ready1), 64'd1);
        chk("ov reg_en", 64'(reg_en1), 64'd0);
        put_word(8'd1, 5'b00001, "ov A");
        put_word(8'd2, 5'b00010, "ov B");
        put_word(8'd3, 5'b00100, "ov C");
        in_valid = 1'b0;

        // Mid-job reset, then a fresh job
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("post rst cmd_ready", 64'(cmd_ready1), 64'd1);
        cmd_valid = 1'b1; cmd_add = 1'b0;
        tick();
        cmd_valid = 1'b0;
        put_word(8'h40, 5'b00001, "fr A");
        put_word(8'h40, 5'b00010, "fr B");
        put_word(8'h20, 5'b00100, "fr C");
        put_word(8'h80, 5'b01000, "fr D");
        put_word(8'd5,  5'b10000, "fr E");
        in_valid = 1'b0;
        tick();
        chk("fr early res_valid", 64'(res_valid1), 64'd0);
        tick();
        chk("fr res_valid", 64'(res_valid1), 64'd1);
        chk("fr res_data", 64'(res_data1), 64'd69);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("fr consumed", 64'(res_valid1), 64'd0);
        chk("fr idle cmd_ready", 64'(cmd_ready1), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
